tcdm_lrwait_queue: RTL and testbench

Per-bank LR/SC reservation queue with waiting semantics (LRWait/SCWait), sitting between the tile request interconnect and one TCDM bank inside the TCDM adapter. It serialises concurrent LRWait requests to one reserved address, grants the reservation to the queue head, and resolves SCWait success. A concurrent store to the reserved address breaks the reservation. It generalises the fixed single-reservation scheme to a parametrised depth, metadata width and optional timeout.

---
 rtl/tcdm_lrwait_pkg.sv | 25 ++
 rtl/tcdm_lrwait_queue_fifo.sv | 55 +++++
 rtl/tcdm_lrwait_queue.sv | 133 +++++++++++++
 tb/tb_tcdm_lrwait_queue.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_lrwait_pkg.sv
// Shared types and constants for the per-bank LRWait/SCWait reservation queue.
package tcdm_lrwait_pkg;

    // Matches the LrWaitQueueSize override used by the MemPool cluster configuration.
    localparam int unsigned LrWaitQueueSize  = 8;
    localparam int unsigned DefaultMetaWidth = 16;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned LrWaitCountWidth = cnt_width(LrWaitQueueSize);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        RESERVED = 2'd2,
        BROKEN   = 2'd3
    } lrwait_state_e;

    typedef struct packed {
        logic [DefaultMetaWidth-1:0] meta;
    } lrwait_entry_t;

endpackage

// File: rtl/tcdm_lrwait_queue_fifo.sv
// Metadata FIFO for the LRWait queue; fifo_v3-style interface with power-of-two depth.
// A push into a full FIFO is legal when a pop happens in the same cycle.
module tcdm_lrwait_queue_fifo #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned DEPTH        = 8,
    localparam int unsigned PtrWidth    = $clog2(DEPTH),
    localparam int unsigned CntWidth    = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CntWidth-1:0]   usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrWidth-1:0]   wptr_q, rptr_q;
    logic [CntWidth-1:0]   cnt_q;

    assign usage_o = cnt_q;
    assign full_o  = (cnt_q == CntWidth'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = (FALL_THROUGH && empty_o) ? data_i : mem_q[rptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= wptr_q + PtrWidth'(1);
            end
            if (pop_i) rptr_q <= rptr_q + PtrWidth'(1);
            unique case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CntWidth'(1);
                2'b01:   cnt_q <= cnt_q - CntWidth'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/tcdm_lrwait_queue.sv
// Per-bank LRWait/SCWait reservation queue; grants the reservation to the queue head.
// Optional head-reservation timeout is enabled by defining LRWAIT_TIMEOUT_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | queue empty, no reservation
// GRANT    | head may issue its LR read (grant_valid_o high)
// RESERVED | head holds a valid reservation on the queue address
// BROKEN   | head reservation invalidated by a store; its SC will fail
module tcdm_lrwait_queue
    import tcdm_lrwait_pkg::*;
#(
    parameter int unsigned QueueDepth    = LrWaitQueueSize,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned MetaWidth     = 16,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          lr_valid_i,
    output logic                          lr_ready_o,
    input  logic [AddrWidth-1:0]          lr_addr_i,
    input  logic [MetaWidth-1:0]          lr_meta_i,
    output logic                          grant_valid_o,
    input  logic                          grant_ready_i,
    output logic [MetaWidth-1:0]          grant_meta_o,
    input  logic                          sc_valid_i,
    input  logic [AddrWidth-1:0]          sc_addr_i,
    input  logic [MetaWidth-1:0]          sc_meta_i,
    output logic                          sc_success_o,
    input  logic                          st_valid_i,
    input  logic [AddrWidth-1:0]          st_addr_i,
    output logic                          empty_o,
    output logic [$clog2(QueueDepth):0]   count_o
);

    localparam int unsigned CntW = cnt_width(QueueDepth);

    lrwait_state_e        state_q;
    logic [AddrWidth-1:0] addr_q;
    logic [MetaWidth-1:0] head_meta;
    logic [CntW-1:0]      usage;
    logic                 fifo_full, fifo_empty;
    logic                 push, pop, head_sc, timeout, remain, st_hit, holding;

    assign holding      = (state_q == RESERVED) || (state_q == BROKEN);
    assign head_sc      = sc_valid_i && holding && (sc_meta_i == head_meta);
    assign pop          = head_sc || timeout;
    assign lr_ready_o   = (!fifo_full || pop) && (fifo_empty || (lr_addr_i == addr_q));
    assign push         = lr_valid_i && lr_ready_o;
    assign remain       = push || (usage > CntW'(1));
    assign st_hit       = st_valid_i && (st_addr_i == addr_q);
    assign sc_success_o = sc_valid_i && (state_q == RESERVED) &&
                          (sc_addr_i == addr_q) && (sc_meta_i == head_meta);
    assign grant_meta_o = grant_valid_o ? head_meta : '0;
    assign empty_o      = fifo_empty;
    assign count_o      = usage;

    tcdm_lrwait_queue_fifo #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (MetaWidth),
        .DEPTH        (QueueDepth)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (usage),
        .data_i  (lr_meta_i),
        .push_i  (push),
        .data_o  (head_meta),
        .pop_i   (pop)
    );

`ifdef LRWAIT_TIMEOUT_EN
    localparam int unsigned TimerW = $clog2(TimeoutCycles) + 1;
    logic [TimerW-1:0] timer_q;

    // Cleared while granting so it reads zero on the first RESERVED cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q <= '0;
        end else if (state_q == GRANT) begin
            timer_q <= '0;
        end else if (holding) begin
            timer_q <= timer_q + TimerW'(1);
        end
    end

    assign timeout = holding && (timer_q == TimerW'(TimeoutCycles - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            grant_valid_o <= 1'b0;
            addr_q        <= '0;
        end else begin
            if (push && fifo_empty) addr_q <= lr_addr_i;
            unique case (state_q)
                IDLE: begin
                    if (push) begin
                        state_q       <= GRANT;
                        grant_valid_o <= 1'b1;
                    end
                end
                GRANT: begin
                    if (grant_ready_i) begin
                        state_q       <= RESERVED;
                        grant_valid_o <= 1'b0;
                    end
                end
                RESERVED, BROKEN: begin
                    // A head pop takes priority over a same-cycle store hit.
                    if (pop) begin
                        state_q       <= remain ? GRANT : IDLE;
                        grant_valid_o <= remain;
                    end else if (state_q == RESERVED && st_hit) begin
                        state_q <= BROKEN;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    grant_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tcdm_lrwait_queue.sv
// Directed self-checking bench for tcdm_lrwait_queue; timeout scenario runs with LRWAIT_TIMEOUT_EN.
module tb_tcdm_lrwait_queue;

    localparam int unsigned QD = 8;
    localparam int unsigned AW = 32;
    localparam int unsigned MW = 16;
    localparam int unsigned TC = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          lr_valid_i = 1'b0;
    logic          lr_ready_o;
    logic [AW-1:0] lr_addr_i = '0;
    logic [MW-1:0] lr_meta_i = '0;
    logic          grant_valid_o;
    logic          grant_ready_i = 1'b0;
    logic [MW-1:0] grant_meta_o;
    logic          sc_valid_i = 1'b0;
    logic [AW-1:0] sc_addr_i = '0;
    logic [MW-1:0] sc_meta_i = '0;
    logic          sc_success_o;
    logic          st_valid_i = 1'b0;
    logic [AW-1:0] st_addr_i = '0;
    logic          empty_o;
    logic [$clog2(QD):0] count_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    tcdm_lrwait_queue #(
        .QueueDepth    (QD),
        .AddrWidth     (AW),
        .MetaWidth     (MW),
        .TimeoutCycles (TC)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .lr_valid_i    (lr_valid_i),
        .lr_ready_o    (lr_ready_o),
        .lr_addr_i     (lr_addr_i),
        .lr_meta_i     (lr_meta_i),
        .grant_valid_o (grant_valid_o),
        .grant_ready_i (grant_ready_i),
        .grant_meta_o  (grant_meta_o),
        .sc_valid_i    (sc_valid_i),
        .sc_addr_i     (sc_addr_i),
        .sc_meta_i     (sc_meta_i),
        .sc_success_o  (sc_success_o),
        .st_valid_i    (st_valid_i),
        .st_addr_i     (st_addr_i),
        .empty_o       (empty_o),
        .count_o       (count_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_in();
        lr_valid_i    = 1'b0;
        grant_ready_i = 1'b0;
        sc_valid_i    = 1'b0;
        st_valid_i    = 1'b0;
    endtask

    task automatic test_reset();
        clear_in();
        rst_ni = 1'b0;
        #3;
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", empty_o); end
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
        checks++; if (grant_valid_o !== 1'b0) begin errors++; $display("FAIL reset_grant got %0b exp 0", grant_valid_o); end
        checks++; if (sc_success_o !== 1'b0) begin errors++; $display("FAIL reset_sc got %0b exp 0", sc_success_o); end
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_single();
        lr_valid_i = 1'b1; lr_addr_i = 32'h40; lr_meta_i = 16'd3;
        #1;
        checks++; if (lr_ready_o !== 1'b1) begin errors++; $display("FAIL single_lr_ready got %0b exp 1", lr_ready_o); end
        step();
        lr_valid_i = 1'b0;
        #1;
        checks++; if (grant_valid_o !== 1'b1) begin errors++; $display("FAIL single_grant got %0b exp 1", grant_valid_o); end
        checks++; if (grant_meta_o !== 16'd3) begin errors++; $display("FAIL single_grant_meta got %0d exp 3", grant_meta_o); end
        checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count_o); end
        step();
        checks++; if (grant_valid_o !== 1'b1 || grant_meta_o !== 16'd3) begin errors++; $display("FAIL single_grant_hold got %0b/%0d exp 1/3", grant_valid_o, grant_meta_o); end
        grant_ready_i = 1'b1;
        step();
        grant_ready_i = 1'b0;
        #1;
        checks++; if (grant_valid_o !== 1'b0) begin errors++; $display("FAIL single_grant_drop got %0b exp 0", grant_valid_o); end
        sc_valid_i = 1'b1; sc_addr_i = 32'h40; sc_meta_i = 16'd3;
        #1;
        checks++; if (sc_success_o !== 1'b1) begin errors++; $display("FAIL single_sc got %0b exp 1", sc_success_o); end
        step();
        sc_valid_i = 1'b0;
        #1;
        checks++; if (empty_o !== 1'b1 || count_o !== 4'd0) begin errors++; $display("FAIL single_empty got %0b/%0d exp 1/0", empty_o, count_o); end
    endtask

    task automatic test_back_to_back();
        for (int m = 1; m <= 3; m++) begin
            lr_valid_i = 1'b1; lr_addr_i = 32'h40; lr_meta_i = MW'(m);
            step();
        end
        lr_valid_i = 1'b0;
        #1;
        checks++; if (count_o !== 4'd3) begin errors++; $display("FAIL b2b_count got %0d exp 3", count_o); end
        for (int m = 1; m <= 3; m++) begin
            checks++; if (grant_valid_o !== 1'b1 || grant_meta_o !== MW'(m)) begin errors++; $display("FAIL b2b_grant got %0b/%0d exp 1/%0d", grant_valid_o, grant_meta_o, m); end
            grant_ready_i = 1'b1;
            step();
            grant_ready_i = 1'b0;
            sc_valid_i = 1'b1; sc_addr_i = 32'h40; sc_meta_i = MW'(m);
            #1;
            checks++; if (sc_success_o !== 1'b1) begin errors++; $display("FAIL b2b_sc got %0b exp 1 (meta %0d)", sc_success_o, m); end
            step();
            sc_valid_i = 1'b0;
            #1;
        end
        checks++; if (empty_o !== 1'b1 || grant_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b/%0b exp 1/0", empty_o, grant_valid_o); end
    endtask

    task automatic test_break();
        logic [AW-1:0] st_addrs [2];
        logic          exp_ok [2];
        st_addrs[0] = 32'h80; exp_ok[0] = 1'b0;
        st_addrs[1] = 32'h84; exp_ok[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            lr_valid_i = 1'b1; lr_addr_i = 32'h80; lr_meta_i = 16'd5;
            step();
            lr_valid_i = 1'b0;
            grant_ready_i = 1'b1;
            step();
            grant_ready_i = 1'b0;
            st_valid_i = 1'b1; st_addr_i = st_addrs[k];
            step();
            st_valid_i = 1'b0;
            sc_valid_i = 1'b1; sc_addr_i = 32'h80; sc_meta_i = 16'd5;
            #1;
            checks++; if (sc_success_o !== exp_ok[k]) begin errors++; $display("FAIL break_sc got %0b exp %0b (store %0h)", sc_success_o, exp_ok[k], st_addrs[k]); end
            step();
            sc_valid_i = 1'b0;
            #1;
            checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL break_pop got %0b exp 1 (store %0h)", empty_o, st_addrs[k]); end
        end
    endtask

    task automatic test_full_mismatch();
        for (int i = 0; i < 8; i++) begin
            lr_valid_i = 1'b1; lr_addr_i = 32'h100; lr_meta_i = MW'(10 + i);
            if (i == 4) begin
                lr_addr_i = 32'h104;
                #1;
                checks++; if (lr_ready_o !== 1'b0) begin errors++; $display("FAIL mismatch_ready got %0b exp 0", lr_ready_o); end
                lr_addr_i = 32'h100;
            end
            step();
        end
        lr_meta_i = 16'd18;
        #1;
        checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", count_o); end
        checks++; if (lr_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", lr_ready_o); end
        lr_valid_i = 1'b0;
        grant_ready_i = 1'b1;
        step();
        grant_ready_i = 1'b0;
        lr_valid_i = 1'b1; lr_addr_i = 32'h100; lr_meta_i = 16'd18;
        sc_valid_i = 1'b1; sc_addr_i = 32'h100; sc_meta_i = 16'd10;
        #1;
        checks++; if (lr_ready_o !== 1'b1 || sc_success_o !== 1'b1) begin errors++; $display("FAIL full_pop_push got %0b/%0b exp 1/1", lr_ready_o, sc_success_o); end
        step();
        clear_in();
        #1;
        checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL full_pop_push_count got %0d exp 8", count_o); end
        for (int m = 11; m <= 18; m++) begin
            checks++; if (grant_valid_o !== 1'b1 || grant_meta_o !== MW'(m)) begin errors++; $display("FAIL full_drain_grant got %0b/%0d exp 1/%0d", grant_valid_o, grant_meta_o, m); end
            grant_ready_i = 1'b1;
            step();
            grant_ready_i = 1'b0;
            sc_valid_i = 1'b1; sc_addr_i = 32'h100; sc_meta_i = MW'(m);
            step();
            sc_valid_i = 1'b0;
            #1;
        end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL full_drain_empty got %0b exp 1", empty_o); end
    endtask

    task automatic test_sc_store_same();
        lr_valid_i = 1'b1; lr_addr_i = 32'h40; lr_meta_i = 16'd7;
        step();
        lr_meta_i = 16'd8;
        step();
        lr_valid_i = 1'b0;
        grant_ready_i = 1'b1;
        step();
        grant_ready_i = 1'b0;
        sc_valid_i = 1'b1; sc_addr_i = 32'h40; sc_meta_i = 16'd9;
        #1;
        checks++; if (sc_success_o !== 1'b0) begin errors++; $display("FAIL nonhead_sc got %0b exp 0", sc_success_o); end
        step();
        sc_valid_i = 1'b0;
        #1;
        checks++; if (count_o !== 4'd2) begin errors++; $display("FAIL nonhead_count got %0d exp 2", count_o); end
        sc_valid_i = 1'b1; sc_meta_i = 16'd7;
        st_valid_i = 1'b1; st_addr_i = 32'h40;
        #1;
        checks++; if (sc_success_o !== 1'b1) begin errors++; $display("FAIL same_cycle_sc got %0b exp 1", sc_success_o); end
        step();
        clear_in();
        #1;
        checks++; if (grant_valid_o !== 1'b1 || grant_meta_o !== 16'd8 || count_o !== 4'd1) begin errors++; $display("FAIL same_cycle_next got %0b/%0d/%0d exp 1/8/1", grant_valid_o, grant_meta_o, count_o); end
        st_valid_i = 1'b1; st_addr_i = 32'h40;
        step();
        st_valid_i = 1'b0;
        grant_ready_i = 1'b1;
        step();
        grant_ready_i = 1'b0;
        sc_valid_i = 1'b1; sc_addr_i = 32'h40; sc_meta_i = 16'd8;
        #1;
        checks++; if (sc_success_o !== 1'b1) begin errors++; $display("FAIL next_head_reserved got %0b exp 1", sc_success_o); end
        step();
        sc_valid_i = 1'b0;
        #1;
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL same_cycle_empty got %0b exp 1", empty_o); end
    endtask

`ifdef LRWAIT_TIMEOUT_EN
    task automatic test_timeout();
        lr_valid_i = 1'b1; lr_addr_i = 32'h300; lr_meta_i = 16'd20;
        step();
        lr_meta_i = 16'd21;
        step();
        lr_valid_i = 1'b0;
        grant_ready_i = 1'b1;
        step();
        grant_ready_i = 1'b0;
        repeat (15) step();
        checks++; if (grant_valid_o !== 1'b0 || count_o !== 4'd2) begin errors++; $display("FAIL timeout_early got %0b/%0d exp 0/2", grant_valid_o, count_o); end
        step();
        checks++; if (grant_valid_o !== 1'b1 || grant_meta_o !== 16'd21 || count_o !== 4'd1) begin errors++; $display("FAIL timeout_evict got %0b/%0d/%0d exp 1/21/1", grant_valid_o, grant_meta_o, count_o); end
        grant_ready_i = 1'b1;
        step();
        grant_ready_i = 1'b0;
        sc_valid_i = 1'b1; sc_addr_i = 32'h300; sc_meta_i = 16'd20;
        #1;
        checks++; if (sc_success_o !== 1'b0) begin errors++; $display("FAIL timeout_stale_sc got %0b exp 0", sc_success_o); end
        step();
        sc_valid_i = 1'b0;
        #1;
        checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL timeout_stale_count got %0d exp 1", count_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if (empty_o !== 1'b1 || grant_valid_o !== 1'b0) begin errors++; $display("FAIL midres_reset got %0b/%0b exp 1/0", empty_o, grant_valid_o); end
        step();
        rst_ni = 1'b1;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_break();
        test_full_mismatch();
        test_sc_store_same();
`ifdef LRWAIT_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
